// File: rtl/axil_reg_if_wr_if.sv
// axil_reg_if_wr_if: AXI4-lite write channel bundle (AW, W, B) between an upstream master and axil_reg_if_wr
// master modport: drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready; sees awready, wready, bresp, bvalid
// slave modport: the mirror image, used by axil_reg_if_wr
interface axil_reg_if_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input awready, wready, bresp, bvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_reg_if_wr.sv
// axil_reg_if_wr: AXI4-lite write endpoint turning AW/W/B handshakes into a register write strobe with wait/ack
// clk, rst        : clock, synchronous active-high reset
// s_axil          : AXI4-lite write channels (slave side); awprot is accepted and discarded
// reg_wr_addr/data/strb : held AW/W contents, stable while reg_wr_en is high
// reg_wr_en       : high for the whole access
// reg_wr_wait/ack : register side stall / acceptance; wait=0 without ack is a decode miss (SLVERR)
// AXIL_REG_IF_WR_TIMEOUT_EN : when defined, an access lasts at most TIMEOUT cycles before completing SLVERR
module axil_reg_if_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT = 4
) (
  input logic clk,
  input logic rst,
  axil_reg_if_wr_if.slave s_axil,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic reg_wr_en,
  input logic reg_wr_wait,
  input logic reg_wr_ack
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic timeout_hit;
  assign s_axil.awready = !aw_held;
  assign s_axil.wready = !w_held;
`ifdef AXIL_REG_IF_WR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  assign timeout_hit = cnt == T_LAST;
  always_ff @(posedge clk)
    cnt <= (rst || state != ACCESS) ? '0 : cnt + 1'b1;
`else
  assign timeout_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axil.bvalid <= 1'b0;
      s_axil.bresp <= 2'b00;
      reg_wr_en <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      if (!aw_held && s_axil.awvalid) begin
        aw_held <= 1'b1;
        aw_addr <= s_axil.awaddr;
      end
      if (!w_held && s_axil.wvalid) begin
        w_held <= 1'b1;
        w_data <= s_axil.wdata;
        w_strb <= s_axil.wstrb;
      end
      case (state)
        IDLE:
          if (aw_held && w_held) begin
            state <= ACCESS;
            reg_wr_en <= 1'b1;
            reg_wr_addr <= aw_addr;
            reg_wr_data <= w_data;
            reg_wr_strb <= w_strb;
          end
        ACCESS:
          if (reg_wr_ack || !reg_wr_wait || timeout_hit) begin
            state <= RESP;
            reg_wr_en <= 1'b0;
            s_axil.bvalid <= 1'b1;
            s_axil.bresp <= reg_wr_ack ? 2'b00 : 2'b10;
            aw_held <= 1'b0;
            w_held <= 1'b0;
          end
        RESP:
          if (s_axil.bready) begin
            state <= IDLE;
            s_axil.bvalid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_if_wr.sv
// tb_axil_reg_if_wr: scoreboard bench for axil_reg_if_wr (OKAY, decode miss, timeout/long wait, back-to-back, reset)
module tb_axil_reg_if_wr;
  localparam int TIMEOUT = 4;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [1:0] resp;
  } exp_t;
  logic clk, rst;
  logic [31:0] reg_wr_addr, reg_wr_data;
  logic [3:0] reg_wr_strb;
  logic reg_wr_en, reg_wr_wait, reg_wr_ack;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  axil_reg_if_wr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  axil_reg_if_wr #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .s_axil(bus),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb),
    .reg_wr_en(reg_wr_en),
    .reg_wr_wait(reg_wr_wait),
    .reg_wr_ack(reg_wr_ack)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic offer(input logic do_aw, input logic do_w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    logic aw_ok = !do_aw;
    logic w_ok = !do_w;
    bus.awaddr = a;
    bus.awprot = 3'b010;
    bus.awvalid = do_aw;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = do_w;
    while (!(aw_ok && w_ok) && t < 20) begin
      if (bus.awready) aw_ok = 1'b1;
      if (bus.wready) w_ok = 1'b1;
      step();
      t++;
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok) bus.wvalid = 1'b0;
    end
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    checks++;
    if (!(aw_ok && w_ok)) begin
      errors++;
      $display("FAIL offer_accept: aw_ok=%0b w_ok=%0b want both 1 within 20 cycles", aw_ok, w_ok);
    end
  endtask
  task automatic observe(input int limit, input int ack_at, output int en_n, output int steps,
                         output logic [31:0] a, output logic [31:0] d, output logic [3:0] s, output logic got_b);
    en_n = 0;
    steps = 0;
    got_b = 1'b0;
    a = '0;
    d = '0;
    s = '0;
    while (steps < limit) begin
      if (bus.bvalid) begin
        got_b = 1'b1;
        break;
      end
      if (reg_wr_en) begin
        en_n++;
        a = reg_wr_addr;
        d = reg_wr_data;
        s = reg_wr_strb;
        if (en_n == ack_at) reg_wr_ack = 1'b1;
      end
      step();
      steps++;
    end
  endtask
  task automatic b_ack();
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.bresp, reg_wr_en} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got aw/w/bv/bresp/en=%b want 110000", {bus.awready, bus.wready, bus.bvalid, bus.bresp, reg_wr_en});
    end
    checks++;
    if ({reg_wr_addr, reg_wr_data, reg_wr_strb} !== 68'h0) begin
      errors++;
      $display("FAIL reset_regs: got addr=%h data=%h strb=%h want 0", reg_wr_addr, reg_wr_data, reg_wr_strb);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_single();
    int en_n, steps;
    logic [31:0] a, d;
    logic [3:0] s;
    logic gb;
    exp_t e;
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b1;
    sb.push_back('{32'h10, 32'hDEADBEEF, 4'hF, 2'b00});
    offer(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    observe(20, 0, en_n, steps, a, d, s, gb);
    e = sb.pop_front();
    checks++;
    if (!gb || steps != 2) begin
      errors++;
      $display("FAIL single_latency: got bvalid=%0b after %0d cycles want 1 after 2", gb, steps);
    end
    checks++;
    if (en_n != 1) begin
      errors++;
      $display("FAIL single_en_cycles: got %0d want 1", en_n);
    end
    checks++;
    if ({a, d, s} !== {e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL single_reg: got %h/%h/%h want %h/%h/%h", a, d, s, e.addr, e.data, e.strb);
    end
    checks++;
    if (bus.bresp !== e.resp) begin
      errors++;
      $display("FAIL single_bresp: got %b want %b", bus.bresp, e.resp);
    end
    b_ack();
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_bclear: got bvalid=%b want 0", bus.bvalid);
    end
  endtask
  task automatic test_w_first();
    int en_n, steps, en_seen;
    logic [31:0] a, d;
    logic [3:0] s;
    logic gb;
    exp_t e;
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b1;
    sb.push_back('{32'h20, 32'h12345678, 4'h3, 2'b00});
    offer(1'b0, 1'b1, 32'h0, 32'h12345678, 4'h3);
    checks++;
    if ({bus.awready, bus.wready} !== 2'b10) begin
      errors++;
      $display("FAIL wfirst_ready: got aw/w ready=%b want 10", {bus.awready, bus.wready});
    end
    en_seen = 0;
    repeat (3) begin
      en_seen += int'(reg_wr_en);
      step();
    end
    checks++;
    if (en_seen != 0 || bus.wready !== 1'b0) begin
      errors++;
      $display("FAIL wfirst_idle: got en cycles=%0d wready=%b want 0 and 0", en_seen, bus.wready);
    end
    offer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    observe(20, 0, en_n, steps, a, d, s, gb);
    e = sb.pop_front();
    checks++;
    if (!gb || en_n != 1 || {a, d, s} !== {e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL wfirst_access: got b=%0b en=%0d %h/%h/%h want 1 1 %h/%h/%h", gb, en_n, a, d, s, e.addr, e.data, e.strb);
    end
    checks++;
    if (bus.bresp !== e.resp) begin
      errors++;
      $display("FAIL wfirst_bresp: got %b want %b", bus.bresp, e.resp);
    end
    b_ack();
  endtask
  task automatic test_decode_miss();
    int en_n, steps, bad;
    logic [31:0] a, d;
    logic [3:0] s;
    logic gb;
    exp_t e;
    reg_wr_wait = 1'b0;
    reg_wr_ack = 1'b0;
    sb.push_back('{32'h34, 32'hA5A5A5A5, 4'h1, 2'b10});
    offer(1'b1, 1'b1, 32'h34, 32'hA5A5A5A5, 4'h1);
    observe(20, 0, en_n, steps, a, d, s, gb);
    e = sb.pop_front();
    checks++;
    if (!gb || en_n != 1 || {a, d, s} !== {e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL miss_access: got b=%0b en=%0d %h/%h/%h want 1 1 %h/%h/%h", gb, en_n, a, d, s, e.addr, e.data, e.strb);
    end
    checks++;
    if (bus.bresp !== e.resp) begin
      errors++;
      $display("FAIL miss_bresp: got %b want %b", bus.bresp, e.resp);
    end
    bad = 0;
    repeat (5) begin
      if (bus.bvalid !== 1'b1 || bus.bresp !== e.resp || reg_wr_en !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL miss_hold: got %0d unstable cycles want 0", bad);
    end
    b_ack();
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL miss_bclear: got bvalid=%b want 0", bus.bvalid);
    end
  endtask
  task automatic test_timeout();
    int en_n, steps;
    logic [31:0] a, d;
    logic [3:0] s;
    logic gb;
    exp_t e;
`ifdef AXIL_REG_IF_WR_TIMEOUT_EN
    int exp_en = TIMEOUT;
    int ack_at = 0;
    sb.push_back('{32'h40, 32'h11112222, 4'hF, 2'b10});
`else
    int exp_en = 25;
    int ack_at = 25;
    sb.push_back('{32'h40, 32'h11112222, 4'hF, 2'b00});
`endif
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b0;
    offer(1'b1, 1'b1, 32'h40, 32'h11112222, 4'hF);
    observe(80, ack_at, en_n, steps, a, d, s, gb);
    reg_wr_ack = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!gb || en_n != exp_en) begin
      errors++;
      $display("FAIL timeout_en_cycles: got b=%0b en=%0d want 1 %0d", gb, en_n, exp_en);
    end
    checks++;
    if ({a, d, s, bus.bresp} !== {e.addr, e.data, e.strb, e.resp}) begin
      errors++;
      $display("FAIL timeout_result: got %h/%h/%h/%b want %h/%h/%h/%b", a, d, s, bus.bresp, e.addr, e.data, e.strb, e.resp);
    end
    b_ack();
  endtask
  task automatic test_back_to_back();
    int en_n, steps, en_seen;
    logic [31:0] a, d;
    logic [3:0] s;
    logic gb;
    exp_t e;
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b1;
    sb.push_back('{32'h50, 32'hAAAA0001, 4'hF, 2'b00});
    sb.push_back('{32'h54, 32'hBBBB0002, 4'hC, 2'b00});
    offer(1'b1, 1'b1, 32'h50, 32'hAAAA0001, 4'hF);
    observe(20, 0, en_n, steps, a, d, s, gb);
    e = sb.pop_front();
    checks++;
    if (!gb || en_n != 1 || {a, d, s} !== {e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL b2b_first: got b=%0b en=%0d %h/%h/%h want 1 1 %h/%h/%h", gb, en_n, a, d, s, e.addr, e.data, e.strb);
    end
    offer(1'b1, 1'b1, 32'h54, 32'hBBBB0002, 4'hC);
    en_seen = 0;
    repeat (3) begin
      en_seen += int'(reg_wr_en);
      step();
    end
    checks++;
    if (en_seen != 0 || bus.bvalid !== 1'b1 || bus.bresp !== e.resp) begin
      errors++;
      $display("FAIL b2b_pending: got en=%0d bvalid=%b bresp=%b want 0 1 %b", en_seen, bus.bvalid, bus.bresp, e.resp);
    end
    b_ack();
    observe(20, 0, en_n, steps, a, d, s, gb);
    e = sb.pop_front();
    checks++;
    if (!gb || en_n != 1 || {a, d, s} !== {e.addr, e.data, e.strb}) begin
      errors++;
      $display("FAIL b2b_second: got b=%0b en=%0d %h/%h/%h want 1 1 %h/%h/%h", gb, en_n, a, d, s, e.addr, e.data, e.strb);
    end
    checks++;
    if (bus.bresp !== e.resp) begin
      errors++;
      $display("FAIL b2b_bresp: got %b want %b", bus.bresp, e.resp);
    end
    b_ack();
  endtask
  task automatic test_reset_mid();
    int t = 0;
    int bad = 0;
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b0;
    offer(1'b1, 1'b1, 32'h60, 32'hCAFEF00D, 4'hF);
    while (!reg_wr_en && t < 10) begin
      step();
      t++;
    end
    checks++;
    if (reg_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_enter: got reg_wr_en=%b want 1", reg_wr_en);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({reg_wr_en, bus.bvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_drop: got en/bvalid=%b want 00", {reg_wr_en, bus.bvalid});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_ready: got aw/w ready=%b want 11", {bus.awready, bus.wready});
    end
    repeat (6) begin
      if (bus.bvalid !== 1'b0 || reg_wr_en !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got %0d cycles with bvalid/en high want 0", bad);
    end
  endtask
  initial begin
    rst = 1'b1;
    reg_wr_wait = 1'b1;
    reg_wr_ack = 1'b0;
    bus.awaddr = '0;
    bus.awprot = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    test_reset();
    test_single();
    test_w_first();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
